// File: rtl/iso14443a_frame_decode.sv
// ISO/IEC 14443-2 Type A modified-Miller frame decoder (PCD -> PICC direction).
// Consumes PCDBitSequence symbols (ERROR/X/Y/Z), detects SOC/EOC, emits data
// bits LSB-first one symbol late, and pulses error on framing violations.
// Optional feature: define ISO14443A_FRAME_DECODE_BIT_COUNT_EN to get the
// bit_count output (bits in last frame).
module iso14443a_frame_decode #(
  parameter int unsigned BIT_COUNT_WIDTH = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seq_valid,
  input  logic [1:0] seq,
  output logic       soc,
  output logic       eoc,
  output logic       data_valid,
  output logic       data_bit,
  output logic       error
`ifdef ISO14443A_FRAME_DECODE_BIT_COUNT_EN
  ,
  output logic [BIT_COUNT_WIDTH-1:0] bit_count
`endif
);

  typedef enum logic [1:0] {
    SYM_ERR = 2'd0,
    SYM_X   = 2'd1,
    SYM_Y   = 2'd2,
    SYM_Z   = 2'd3
  } sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t state;
  sym_t   prev;
  logic   pending;
  sym_t   sym;

  assign sym = sym_t'(seq);

`ifdef ISO14443A_FRAME_DECODE_BIT_COUNT_EN
  function automatic logic [BIT_COUNT_WIDTH-1:0] sat_inc(input logic [BIT_COUNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
`endif

  // Frame FSM: a bit is held pending until the next symbol proves it is not the EOC logic 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= SYM_ERR;
      pending    <= 1'b0;
      soc        <= 1'b0;
      eoc        <= 1'b0;
      data_valid <= 1'b0;
      data_bit   <= 1'b0;
      error      <= 1'b0;
`ifdef ISO14443A_FRAME_DECODE_BIT_COUNT_EN
      bit_count  <= '0;
`endif
    end else begin
      soc        <= 1'b0;
      eoc        <= 1'b0;
      data_valid <= 1'b0;
      error      <= 1'b0;
      if (seq_valid) begin
        case (state)
          IDLE: begin
            if (sym == SYM_Z) begin
              soc   <= 1'b1;
              state <= FIRST;
`ifdef ISO14443A_FRAME_DECODE_BIT_COUNT_EN
              bit_count <= '0;
`endif
            end
          end
          FIRST: begin
            case (sym)
              SYM_X: begin
                pending <= 1'b1;
                prev    <= SYM_X;
                state   <= DATA;
              end
              SYM_Z: begin
                pending <= 1'b0;
                prev    <= SYM_Z;
                state   <= DATA;
              end
              default: begin
                error <= 1'b1;
                state <= IDLE;
              end
            endcase
          end
          DATA: begin
            case (sym)
              SYM_X: begin
                data_valid <= 1'b1;
                data_bit   <= pending;
                pending    <= 1'b1;
                prev       <= SYM_X;
`ifdef ISO14443A_FRAME_DECODE_BIT_COUNT_EN
                bit_count  <= sat_inc(bit_count);
`endif
              end
              SYM_Z: begin
                if (prev == SYM_X) begin
                  error <= 1'b1;
                  state <= IDLE;
                end else begin
                  data_valid <= 1'b1;
                  data_bit   <= pending;
                  pending    <= 1'b0;
                  prev       <= SYM_Z;
`ifdef ISO14443A_FRAME_DECODE_BIT_COUNT_EN
                  bit_count  <= sat_inc(bit_count);
`endif
                end
              end
              SYM_Y: begin
                if (prev == SYM_X) begin
                  data_valid <= 1'b1;
                  data_bit   <= pending;
                  pending    <= 1'b0;
                  prev       <= SYM_Y;
`ifdef ISO14443A_FRAME_DECODE_BIT_COUNT_EN
                  bit_count  <= sat_inc(bit_count);
`endif
                end else begin
                  // Y after Y/Z: the pending 0 was the EOC logic 0
                  eoc   <= 1'b1;
                  state <= IDLE;
                end
              end
              default: begin
                error <= 1'b1;
                state <= IDLE;
              end
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
